// File: rtl/sdio_wbarb.sv
// sdio_wbarb: round-robin two-master Wishbone arbiter for the SDIO control port; watchdog enabled by SDIO_WBARB_TIMEOUT_EN
module sdio_wbarb #(
    parameter int MW        = 32,
    parameter int AW        = 3,
    parameter int LGTIMEOUT = 10
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [MW-1:0]   i_a_data,
    input  logic [MW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [MW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [MW-1:0]   i_b_data,
    input  logic [MW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [MW-1:0]   o_b_data,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [MW-1:0]   o_wb_data,
    output logic [MW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic [MW-1:0]   i_wb_data
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t     r_state;
    logic       r_last;
    logic [3:0] r_nout;
    logic       w_own_a, w_own_b, w_cyc, w_stb, w_other_cyc;
    logic       w_full, w_accept, w_ack, w_timeout;

    assign w_own_a     = r_state == OWN_A;
    assign w_own_b     = r_state == OWN_B;
    assign w_cyc       = w_own_a ? i_a_cyc : w_own_b & i_b_cyc;
    assign w_stb       = w_own_a ? i_a_stb : w_own_b & i_b_stb;
    assign w_other_cyc = w_own_a ? i_b_cyc : i_a_cyc;
    assign w_full      = &r_nout;

    // a watchdog abort drops the slave cycle for the cycle it fires
    assign o_wb_cyc  = w_cyc & ~w_timeout;
    assign o_wb_stb  = o_wb_cyc & w_stb & ~w_full;
    assign o_wb_we   = w_own_a ? i_a_we : w_own_b & i_b_we;
    assign o_wb_addr = w_own_a ? i_a_addr : w_own_b ? i_b_addr : '0;
    assign o_wb_data = w_own_a ? i_a_data : w_own_b ? i_b_data : '0;
    assign o_wb_sel  = w_own_a ? i_a_sel  : w_own_b ? i_b_sel  : '0;

    assign w_accept = o_wb_stb & ~i_wb_stall;
    // acks with nothing outstanding (including leftovers from an aborted cycle) are dropped
    assign w_ack    = o_wb_cyc & i_wb_ack & (|r_nout);

    assign o_a_stall = ~w_own_a | i_wb_stall | w_full | w_timeout;
    assign o_b_stall = ~w_own_b | i_wb_stall | w_full | w_timeout;
    assign o_a_ack   = w_own_a & w_ack;
    assign o_b_ack   = w_own_b & w_ack;
    assign o_a_err   = w_own_a & w_timeout;
    assign o_b_err   = w_own_b & w_timeout;
    assign o_a_data  = i_wb_data;
    assign o_b_data  = i_wb_data;

    // grant owner, remember the last owner for round-robin, count outstanding requests
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_nout  <= '0;
        end else begin
            r_nout <= (~w_cyc | w_timeout) ? '0 : r_nout + 4'(w_accept) - 4'(w_ack);
            if (r_state == IDLE)
                r_state <= (i_a_cyc && (!i_b_cyc || r_last)) ? OWN_A : i_b_cyc ? OWN_B : IDLE;
            else if (!w_cyc || w_timeout) begin
                r_last  <= w_own_b;
                r_state <= (w_timeout || !w_other_cyc) ? IDLE : w_own_a ? OWN_B : OWN_A;
            end
        end
    end

`ifdef SDIO_WBARB_TIMEOUT_EN
    logic [LGTIMEOUT-1:0] r_wdog;

    assign w_timeout = w_cyc & (|r_nout) & (&r_wdog) & ~i_wb_ack;

    // watchdog counts ack-less cycles while requests are outstanding
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_wdog <= '0;
        else
            r_wdog <= (~w_cyc | ~(|r_nout) | i_wb_ack | w_timeout) ? '0 : r_wdog + LGTIMEOUT'(1);
    end
`else
    assign w_timeout = LGTIMEOUT < 0;
`endif
endmodule

// File: tb/tb_sdio_wbarb.sv
// tb_sdio_wbarb: directed and randomized checks of sdio_wbarb against a cycle-level ownership model
module tb_sdio_wbarb;
    localparam int MW  = 32;
    localparam int AW  = 3;
    localparam int LGT = 4;

    logic clk, rst;
    logic a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [MW-1:0] a_data, b_data;
    logic [MW/8-1:0] a_sel, b_sel;
    logic wb_stall, wb_ack;
    logic [MW-1:0] wb_data;
    logic o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
    logic [MW-1:0] o_a_data, o_b_data;
    logic o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [MW-1:0] o_wb_data;
    logic [MW/8-1:0] o_wb_sel;

    // model: owner 0=none 1=A 2=B, last owner, outstanding count, watchdog count
    int m_own, m_last, m_nout, m_wd;
    int n_chk, n_fail, n_acks;
    logic own_cyc, own_stb, e_full, e_tmo, e_cyc, e_stb, e_ack, acc, oth;

    sdio_wbarb #(.MW(MW), .AW(AW), .LGTIMEOUT(LGT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data), .i_a_sel(a_sel),
        .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_data(o_a_data),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data), .i_b_sel(b_sel),
        .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_data(o_b_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_last = 2; m_nout = 0; m_wd = 0;
    endtask

    task automatic model_eval();
        own_cyc = m_own == 1 ? a_cyc : m_own == 2 ? b_cyc : 1'b0;
        own_stb = m_own == 1 ? a_stb : m_own == 2 ? b_stb : 1'b0;
        e_full  = m_nout == 15;
`ifdef SDIO_WBARB_TIMEOUT_EN
        e_tmo = own_cyc && m_nout > 0 && m_wd == (1 << LGT) - 1 && !wb_ack;
`else
        e_tmo = 1'b0;
`endif
        e_cyc = own_cyc && !e_tmo;
        e_stb = e_cyc && own_stb && !e_full;
        e_ack = e_cyc && wb_ack && m_nout > 0;
    endtask

    task automatic check_outputs();
        model_eval();
        chk("ctl", 64'({o_wb_cyc, o_wb_stb, o_wb_we, o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err}),
            64'({e_cyc, e_stb, m_own == 1 ? a_we : m_own == 2 && b_we,
                 m_own != 1 || wb_stall || e_full || e_tmo, m_own == 1 && e_ack, m_own == 1 && e_tmo,
                 m_own != 2 || wb_stall || e_full || e_tmo, m_own == 2 && e_ack, m_own == 2 && e_tmo}));
        chk("req", 64'({o_wb_addr, o_wb_sel, o_wb_data}),
            m_own == 1 ? 64'({a_addr, a_sel, a_data}) : m_own == 2 ? 64'({b_addr, b_sel, b_data}) : 64'(0));
        chk("rdata", 64'({o_a_data, o_b_data}), 64'({wb_data, wb_data}));
    endtask

    // advance the model by one clock using the inputs present at the edge
    task automatic model_update();
        model_eval();
        if (rst) begin
            model_reset();
            return;
        end
        acc = e_stb && !wb_stall;
        m_wd = (!own_cyc || m_nout == 0 || wb_ack || e_tmo) ? 0 : m_wd + 1;
        if (m_own == 0) begin
            m_nout = 0;
            if (a_cyc && b_cyc) m_own = m_last == 2 ? 1 : 2;
            else if (a_cyc) m_own = 1;
            else if (b_cyc) m_own = 2;
        end else if (!own_cyc || e_tmo) begin
            oth = m_own == 1 ? b_cyc : a_cyc;
            m_last = m_own;
            m_own = (oth && !e_tmo) ? 3 - m_own : 0;
            m_nout = 0;
        end else
            m_nout = m_nout + int'(acc) - int'(e_ack);
    endtask

    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, 64'({o_wb_cyc, o_wb_stb, o_wb_we, o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err,
                      o_wb_addr, o_wb_data, o_wb_sel}), 64'({9'b000100100, 39'b0}));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        sample();
        chk_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; n_acks = 0;
        a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_data = '0; a_sel = '0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_data = '0; b_sel = '0;
        wb_stall = 0; wb_ack = 0; wb_data = '0;
        model_reset();
        do_reset();

        // A: single write to register 2
        a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 3'd2; a_data = 32'h12345678; a_sel = 4'hF;
        sample(); chk("t1_b_stall", 64'(o_b_stall), 64'(1)); tick();
        sample(); chk("t1_req", 64'({o_wb_stb, o_wb_addr, o_wb_data}), 64'({1'b1, 3'd2, 32'h12345678})); tick();
        a_stb = 0; wb_ack = 1;
        sample(); chk("t1_ack", 64'({o_a_ack, o_b_stall, o_b_ack}), 64'(3'b110)); tick();
        a_cyc = 0; a_we = 0; wb_ack = 0;
        sample(); chk("t1_ack_once", 64'(o_a_ack), 64'(0)); tick();

        // tie from reset, handover, round-robin tie
        do_reset();
        a_cyc = 1; b_cyc = 1;
        sample(); tick();
        sample(); chk("t2_grant_a", 64'({o_a_stall, o_b_stall}), 64'(2'b01)); tick();
        a_cyc = 0;
        sample(); chk("t2_gap", 64'(o_wb_cyc), 64'(0)); tick();
        sample(); chk("t2_grant_b", 64'({o_a_stall, o_b_stall}), 64'(2'b10)); tick();
        b_cyc = 0;
        sample(); tick();
        a_cyc = 1; b_cyc = 1;
        sample(); tick();
        sample(); chk("t2_rr_a", 64'({o_a_stall, o_b_stall}), 64'(2'b01)); tick();
        a_cyc = 0; b_cyc = 0;
        sample(); tick();

        // B: three pipelined reads acked two cycles later
        b_cyc = 1; b_we = 0; b_addr = 3'd5; b_sel = 4'hF;
        sample(); tick();
        for (int t = 0; t < 6; t++) begin
            b_stb = t < 3;
            b_cyc = t < 5;
            wb_ack = t >= 2 && t < 5;
            wb_data = wb_ack ? 32'hA0 + t - 2 : 32'hDEADBEEF;
            sample();
            chk("t3_ack", 64'(o_b_ack), 64'(wb_ack));
            if (o_b_ack) begin
                chk("t3_rdata", 64'(o_b_data), 64'(32'hA0 + n_acks));
                n_acks++;
            end
            tick();
        end
        wb_ack = 0;
        chk("t3_acks", 64'(n_acks), 64'(3));

        // A: fill to 15 outstanding, abort, late ack discarded
        a_cyc = 1; a_stb = 1; a_we = 0;
        sample(); tick();
        for (int t = 0; t < 18; t++) begin
            a_cyc = t < 16; a_stb = t < 16; wb_ack = t == 17;
            sample();
            if (t == 14) chk("t4_stb14", 64'({o_wb_stb, o_a_stall}), 64'(2'b10));
            if (t == 15) chk("t4_full", 64'({o_wb_stb, o_a_stall}), 64'(2'b01));
            if (t == 16) chk("t4_abort", 64'(o_wb_cyc), 64'(0));
            if (t == 17) chk("t4_late_ack", 64'({o_a_ack, o_b_ack}), 64'(2'b00));
            tick();
        end
        wb_ack = 0;

`ifdef SDIO_WBARB_TIMEOUT_EN
        // A: unacknowledged read times out, pending B takes over
        a_cyc = 1; a_stb = 1;
        sample(); tick();
        for (int t = 0; t < 19; t++) begin
            a_stb = t == 0; a_cyc = t < 17; b_cyc = t > 0;
            sample();
            if (t == 15) chk("t5_no_err", 64'(o_a_err), 64'(0));
            if (t == 16) chk("t5_err", 64'({o_a_err, o_wb_cyc}), 64'(2'b10));
            if (t == 18) chk("t5_b_grant", 64'(o_b_stall), 64'(0));
            tick();
        end
`endif

        // asynchronous reset while B owns with two outstanding
        a_cyc = 0; a_stb = 0; b_cyc = 1; b_stb = 0;
        sample(); tick();
        b_stb = 1;
        sample(); tick();
        sample(); tick();
        b_stb = 0;
        sample(); chk("t6_b_own", 64'({o_wb_cyc, o_b_stall}), 64'(2'b10));
        rst = 1;
        model_reset();
        #1;
        chk_reset_outputs("t6_rst_async");
        tick();
        rst = 0; a_cyc = 1; b_cyc = 1;
        sample(); tick();
        sample(); chk("t6_tie_a", 64'({o_a_stall, o_b_stall}), 64'(2'b01)); tick();

        // randomized traffic with periodic ack-free stretches
        for (int c = 0; c < 3000; c++) begin
            a_cyc = a_cyc ? $urandom_range(15, 0) != 0 : $urandom_range(3, 0) == 0;
            b_cyc = b_cyc ? $urandom_range(15, 0) != 0 : $urandom_range(3, 0) == 0;
            a_stb = a_cyc && $urandom_range(1, 0) == 1;
            b_stb = b_cyc && $urandom_range(1, 0) == 1;
            a_we = 1'($urandom); a_addr = 3'($urandom); a_data = $urandom; a_sel = 4'($urandom);
            b_we = 1'($urandom); b_addr = 3'($urandom); b_data = $urandom; b_sel = 4'($urandom);
            wb_stall = $urandom_range(3, 0) == 0;
            wb_ack = (c % 300) < 260 && $urandom_range(2, 0) == 0;
            wb_data = $urandom;
            sample();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
